fetch_prefetch: RTL and testbench

Parametrised instruction-fetch stage with a prefetch queue, N selectable program banks and branch redirect. It replaces the single-cycle fetch and sits between the instruction memories (combinational read) and decode. Each cycle it fetches one word into a circular queue and presents the oldest entry to decode over a valid/ready handshake. A redirect or a bank switch flushes the queue and restarts fetch.

---
 rtl/fetch_pkg.sv | 19 +
 rtl/fetch_queue.sv | 73 +++++++
 rtl/fetch_prefetch.sv | 111 +++++++++++
 tb/tb_fetch_prefetch.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared constants and entry type for the instruction-fetch prefetch stage.
package fetch_pkg;

  localparam int FETCH_XLEN      = 32;
  localparam int FETCH_DEPTH     = 4;
  localparam int FETCH_NUM_BANKS = 2;
  localparam int FETCH_RESET_PC  = 0;

  typedef struct packed {
    logic [FETCH_XLEN-1:0] pc;
    logic [FETCH_XLEN-1:0] instr;
  } fetch_entry_t;

  // A single bank still needs a one-bit select port.
  function automatic int bank_width(input int num_banks);
    return (num_banks > 1) ? $clog2(num_banks) : 1;
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Circular prefetch buffer: push, pop, and flush-and-load of a single entry.
module fetch_queue #(
  parameter int W     = 64,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic         flush_i,
  input  logic [W-1:0] wdata_i,
  output logic [W-1:0] rdata_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  assign rdata_o = mem_q[head_q];
  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);

  // A flush restarts the buffer with the loaded word as its only entry.
  always_comb begin
    // NOTE: every next-state variable gets a default first so no path leaves it unassigned (no latch).
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush_i) begin
      head_d  = '0;
      tail_d  = PW'(1);
      count_d = CW'(1);
    end else begin
      if (push_i) tail_d = tail_q + PW'(1);
      if (pop_i)  head_d = head_q + PW'(1);
      case ({push_i, pop_i})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // NOTE: storage is reset because the head entry drives out_pc/out_instr even while empty.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (flush_i) begin
      mem_q[0] <= wdata_i;
    end else if (push_i) begin
      mem_q[tail_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/fetch_prefetch.sv
// Instruction fetch with prefetch queue, banked program memories and branch redirect.
// Optional FETCH_PERF_EN adds saturating fetched/flush/stall counters.
module fetch_prefetch
  import fetch_pkg::*;
#(
  parameter int              XLEN      = FETCH_XLEN,
  parameter int              NUM_BANKS = FETCH_NUM_BANKS,
  parameter int              DEPTH     = FETCH_DEPTH,
  parameter logic [XLEN-1:0] RESET_PC  = XLEN'(FETCH_RESET_PC),
  parameter int              BANK_W    = bank_width(NUM_BANKS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [BANK_W-1:0]         bank_sel,
  input  logic                      redirect_valid,
  input  logic [XLEN-1:0]           redirect_pc,
  output logic [XLEN-1:0]           imem_addr,
  input  logic [NUM_BANKS*XLEN-1:0] imem_rdata,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [XLEN-1:0]           out_instr,
  output logic [XLEN-1:0]           out_pc,
`ifdef FETCH_PERF_EN
  output logic [XLEN-1:0]           out_pc_next,
  output logic [XLEN-1:0]           perf_fetched,
  output logic [XLEN-1:0]           perf_flushes,
  output logic [XLEN-1:0]           perf_stalls
`else
  output logic [XLEN-1:0]           out_pc_next
`endif
);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } entry_t;

  entry_t            fetch_entry, head_entry;
  logic [XLEN-1:0]   fpc_q, fpc_d, fetch_word, refetch_pc;
  logic [BANK_W-1:0] bank_q, bank_d;
  logic              bank_change, flush, push, pop, q_full, q_empty;

  // Out-of-range selects fall back to bank 0.
  always_comb begin
    fetch_word = imem_rdata[XLEN-1:0];
    for (int b = 1; b < NUM_BANKS; b++) begin
      if (bank_sel == BANK_W'(b)) fetch_word = imem_rdata[b*XLEN +: XLEN];
    end
  end

  assign bank_change = (bank_sel != bank_q);
  assign flush       = redirect_valid | bank_change;
  assign refetch_pc  = q_empty ? fpc_q : head_entry.pc;
  assign imem_addr   = redirect_valid ? redirect_pc : (bank_change ? refetch_pc : fpc_q);

  assign out_valid   = !q_empty && !flush;
  assign pop         = out_valid && out_ready;
  assign push        = !flush && (!q_full || pop);
  assign fetch_entry = '{pc: imem_addr, instr: fetch_word};

  assign out_pc      = head_entry.pc;
  assign out_instr   = head_entry.instr;
  assign out_pc_next = head_entry.pc + XLEN'(1);

  always_comb begin
    fpc_d  = fpc_q;
    bank_d = bank_q;
    if (flush || push) fpc_d = imem_addr + XLEN'(1);
    if (flush)         bank_d = bank_sel;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fpc_q  <= RESET_PC;
      bank_q <= '0;
    end else begin
      fpc_q  <= fpc_d;
      bank_q <= bank_d;
    end
  end

  fetch_queue #(
    .W     ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (flush),
    .wdata_i (fetch_entry),
    .rdata_o (head_entry),
    .full_o  (q_full),
    .empty_o (q_empty)
  );

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_fetched <= '0;
      perf_flushes <= '0;
      perf_stalls  <= '0;
    end else begin
      if (push && perf_fetched != '1)              perf_fetched <= perf_fetched + XLEN'(1);
      if (flush && perf_flushes != '1)             perf_flushes <= perf_flushes + XLEN'(1);
      if (q_full && !pop && perf_stalls != '1)     perf_stalls  <= perf_stalls + XLEN'(1);
    end
  end
`endif

endmodule

// File: tb/tb_fetch_prefetch.sv
// Directed self-checking bench for fetch_prefetch (default parameters).
module tb_fetch_prefetch;
  import fetch_pkg::*;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic [0:0]      bank_sel;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic [XLEN-1:0] imem_addr;
  logic [2*XLEN-1:0] imem_rdata;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_instr;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_pc_next;
`ifdef FETCH_PERF_EN
  logic [XLEN-1:0] perf_fetched, perf_flushes, perf_stalls;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  function automatic logic [XLEN-1:0] bank0_word(input logic [XLEN-1:0] a);
    return 32'h0000_1000 + a;
  endfunction

  function automatic logic [XLEN-1:0] bank1_word(input logic [XLEN-1:0] a);
    return 32'h0000_2000 + a;
  endfunction

  assign imem_rdata = {bank1_word(imem_addr), bank0_word(imem_addr)};

  fetch_prefetch dut (
    .clk            (clk),
    .rst            (rst),
    .bank_sel       (bank_sel),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
`ifdef FETCH_PERF_EN
    .out_pc_next    (out_pc_next),
    .perf_fetched   (perf_fetched),
    .perf_flushes   (perf_flushes),
    .perf_stalls    (perf_stalls)
`else
    .out_pc_next    (out_pc_next)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset, then release between edges; ends before the first active edge.
  task automatic do_reset();
    rst            = 1'b0;
    bank_sel       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    out_ready      = 1'b1;
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    fetch_entry_t exp;
    rst            = 1'b0;
    bank_sel       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    out_ready      = 1'b1;
    #12;
    checks++;
    if ({out_valid, out_pc, out_instr, out_pc_next} !== {1'b0, 32'h0, 32'h0, 32'h1}) begin
      failures++;
      $display("FAIL reset_outputs got v=%0b pc=%h instr=%h next=%h want v=0 pc=0 instr=0 next=1",
               out_valid, out_pc, out_instr, out_pc_next);
    end
    checks++;
    if (imem_addr !== 32'h0) begin
      failures++;
      $display("FAIL reset_imem_addr got %h want 0", imem_addr);
    end
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL release_valid got %0b want 0", out_valid);
    end
    tick();
    exp.pc    = 32'h0;
    exp.instr = 32'h1000;
    checks++;
    if ({out_valid, out_pc, out_instr} !== {1'b1, exp.pc, exp.instr}) begin
      failures++;
      $display("FAIL first_fetch got v=%0b pc=%h instr=%h want v=1 pc=%h instr=%h",
               out_valid, out_pc, out_instr, exp.pc, exp.instr);
    end
  endtask

  task automatic test_stream();
    for (int i = 0; i < 8; i++) begin
      checks++;
      if ({out_valid, out_pc, out_instr, out_pc_next} !==
          {1'b1, 32'(i), 32'(32'h1000 + i), 32'(i + 1)}) begin
        failures++;
        $display("FAIL stream[%0d] got v=%0b pc=%h instr=%h next=%h want v=1 pc=%h instr=%h next=%h",
                 i, out_valid, out_pc, out_instr, out_pc_next, i, 32'h1000 + i, i + 1);
      end
      tick();
    end
  endtask

  task automatic test_stall();
    do_reset();
    out_ready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (c >= 4) begin
        checks++;
        if ({imem_addr, out_pc} !== {32'h4, 32'h0}) begin
          failures++;
          $display("FAIL stall_hold[%0d] got addr=%h pc=%h want addr=4 pc=0", c, imem_addr, out_pc);
        end
      end
    end
    out_ready = 1'b1;
    #1;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if ({out_valid, out_pc, out_instr} !== {1'b1, 32'(i), 32'(32'h1000 + i)}) begin
        failures++;
        $display("FAIL drain[%0d] got v=%0b pc=%h instr=%h want v=1 pc=%h instr=%h",
                 i, out_valid, out_pc, out_instr, i, 32'h1000 + i);
      end
      tick();
    end
  endtask

  task automatic test_redirect();
    do_reset();
    out_ready = 1'b0;
    repeat (3) tick();
    checks++;
    if ({out_valid, out_pc, imem_addr} !== {1'b1, 32'h0, 32'h3}) begin
      failures++;
      $display("FAIL redir_pre got v=%0b pc=%h addr=%h want v=1 pc=0 addr=3", out_valid, out_pc, imem_addr);
    end
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    out_ready      = 1'b1;
    #1;
    checks++;
    if ({out_valid, imem_addr} !== {1'b0, 32'h40}) begin
      failures++;
      $display("FAIL redir_cycle got v=%0b addr=%h want v=0 addr=40", out_valid, imem_addr);
    end
    tick();
    redirect_valid = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({out_valid, out_pc, out_pc_next, out_instr} !==
          {1'b1, 32'(32'h40 + i), 32'(32'h41 + i), 32'(32'h1040 + i)}) begin
        failures++;
        $display("FAIL redir_after[%0d] got v=%0b pc=%h next=%h instr=%h want v=1 pc=%h next=%h instr=%h",
                 i, out_valid, out_pc, out_pc_next, out_instr, 32'h40 + i, 32'h41 + i, 32'h1040 + i);
      end
      tick();
    end
  endtask

  task automatic test_bank_switch();
    do_reset();
    repeat (6) tick();
    checks++;
    if ({out_valid, out_pc, out_instr} !== {1'b1, 32'h5, 32'h1005}) begin
      failures++;
      $display("FAIL bank_pre got v=%0b pc=%h instr=%h want v=1 pc=5 instr=1005", out_valid, out_pc, out_instr);
    end
    bank_sel = 1'b1;
    #1;
    checks++;
    if ({out_valid, imem_addr} !== {1'b0, 32'h5}) begin
      failures++;
      $display("FAIL bank_cycle got v=%0b addr=%h want v=0 addr=5", out_valid, imem_addr);
    end
    tick();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({out_valid, out_pc, out_instr} !== {1'b1, 32'(5 + i), 32'(32'h2005 + i)}) begin
        failures++;
        $display("FAIL bank_after[%0d] got v=%0b pc=%h instr=%h want v=1 pc=%h instr=%h",
                 i, out_valid, out_pc, out_instr, 5 + i, 32'h2005 + i);
      end
      tick();
    end
  endtask

  task automatic test_pc_wrap();
    do_reset();
    repeat (2) tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFF;
    tick();
    redirect_valid = 1'b0;
    #1;
    checks++;
    if ({out_valid, out_pc, out_pc_next, out_instr} !== {1'b1, 32'hFFFF_FFFF, 32'h0, 32'h0000_0FFF}) begin
      failures++;
      $display("FAIL wrap_top got v=%0b pc=%h next=%h instr=%h want v=1 pc=ffffffff next=0 instr=fff",
               out_valid, out_pc, out_pc_next, out_instr);
    end
    tick();
    checks++;
    if ({out_valid, out_pc, out_instr} !== {1'b1, 32'h0, 32'h1000}) begin
      failures++;
      $display("FAIL wrap_zero got v=%0b pc=%h instr=%h want v=1 pc=0 instr=1000", out_valid, out_pc, out_instr);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    repeat (3) tick();
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if ({out_valid, out_pc, out_instr, out_pc_next, imem_addr} !==
        {1'b0, 32'h0, 32'h0, 32'h1, 32'h0}) begin
      failures++;
      $display("FAIL async_clear got v=%0b pc=%h instr=%h next=%h addr=%h want v=0 pc=0 instr=0 next=1 addr=0",
               out_valid, out_pc, out_instr, out_pc_next, imem_addr);
    end
`ifdef FETCH_PERF_EN
    checks++;
    if ({perf_fetched, perf_flushes, perf_stalls} !== 96'h0) begin
      failures++;
      $display("FAIL perf_clear got f=%h fl=%h s=%h want 0 0 0", perf_fetched, perf_flushes, perf_stalls);
    end
`endif
    bank_sel = 1'b1;
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if ({out_valid, imem_addr} !== {1'b0, 32'h0}) begin
      failures++;
      $display("FAIL reset_bank_flush got v=%0b addr=%h want v=0 addr=0", out_valid, imem_addr);
    end
    tick();
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({out_valid, out_pc, out_instr} !== {1'b1, 32'(i), 32'(32'h2000 + i)}) begin
        failures++;
        $display("FAIL restart[%0d] got v=%0b pc=%h instr=%h want v=1 pc=%h instr=%h",
                 i, out_valid, out_pc, out_instr, i, 32'h2000 + i);
      end
      tick();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_bank_switch();
    test_pc_wrap();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
